comparator_search: RTL and testbench

Sequential binary-search controller that sits on the stimulus side of the team's 4-bit magnitude `comparator`. It drives the comparator's `A` operand with successive guesses while `B` is tied to an unknown target, and reads back `A_grt_B` / `A_less_B` / `A_eq_B`. It converges on the target value and reports the value, success, and the number of comparisons used. Typical uses are threshold discovery and as a self-checking exerciser for comparator instances.

---
 rtl/comparator_search_if.sv | 28 ++
 rtl/comparator_search.sv | 143 ++++++++++++++
 tb/tb_comparator_search.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_search_if.sv
// Handshake and comparator-side bus of the binary-search controller.
// The slave modport is the controller; the master modport is the stimulus/comparator side.
interface comparator_search_if #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 3
);
  logic             start;
  logic             A_grt_B;
  logic             A_less_B;
  logic             A_eq_B;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [CNTW-1:0]  steps;

  modport master (
    output start, A_grt_B, A_less_B, A_eq_B,
    input  guess, busy, done, found, err, result, steps
  );

  modport slave (
    input  start, A_grt_B, A_less_B, A_eq_B,
    output guess, busy, done, found, err, result, steps
  );
endinterface

// File: rtl/comparator_search.sv
// Binary-search controller: drives guesses into a magnitude comparator and
// converges on the hidden target, reporting value, success and step count.
module comparator_search #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 3
) (
  input  logic                clk,
  input  logic                rst,
  comparator_search_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] FIRST_GUESS = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] guess_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;
  logic             err_q;
  logic [WIDTH-1:0] result_q;
  logic [CNTW-1:0]  steps_q;

  logic [WIDTH-1:0] hi_dec_d;
  logic [WIDTH-1:0] lo_inc_d;
  logic [WIDTH-1:0] guess_grt_d;
  logic [WIDTH-1:0] guess_less_d;
  logic             onehot_d;

  // Next guesses for both narrowing directions, midpoint taken in WIDTH+1 bits
  always_comb begin
    hi_dec_d     = guess_q - WIDTH'(1);
    lo_inc_d     = guess_q + WIDTH'(1);
    guess_grt_d  = WIDTH'({1'b0, lo_q} + (({1'b0, hi_dec_d} - {1'b0, lo_q}) >> 1));
    guess_less_d = WIDTH'({1'b0, lo_inc_d} + (({1'b0, hi_q} - {1'b0, lo_inc_d}) >> 1));
    case ({bus.A_grt_B, bus.A_less_B, bus.A_eq_B})
      3'b100:  onehot_d = 1'b1;
      3'b010:  onehot_d = 1'b1;
      3'b001:  onehot_d = 1'b1;
      default: onehot_d = 1'b0;
    endcase
  end

  // Search FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= {WIDTH{1'b0}};
      hi_q     <= ALL_ONES;
      guess_q  <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      steps_q  <= {CNTW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            lo_q     <= {WIDTH{1'b0}};
            hi_q     <= ALL_ONES;
            guess_q  <= FIRST_GUESS;
            steps_q  <= {CNTW{1'b0}};
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b1;
            state_q  <= S_SEARCH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_SEARCH: begin
          steps_q <= steps_q + CNTW'(1);
          if (!onehot_d) begin
            err_q   <= 1'b1;
            found_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (bus.A_eq_B) begin
            result_q <= guess_q;
            found_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (bus.A_grt_B) begin
            if (guess_q == lo_q) begin
              found_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              hi_q    <= hi_dec_d;
              guess_q <= guess_grt_d;
            end
          end else begin
            // Only A_less_B remains once the flags are known one-hot
            if (guess_q == hi_q) begin
              found_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              lo_q    <= lo_inc_d;
              guess_q <= guess_less_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
  assign bus.steps  = steps_q;

endmodule

// File: tb/tb_comparator_search.sv
// Self-checking bench for comparator_search: table-driven searches against a
// behavioural comparator, plus directed error, reset and back-to-back sequences.
module tb_comparator_search;

  logic clk;
  logic rst;
  logic [3:0] target;
  logic       force_en;
  logic [2:0] force_flags;   // {grt, less, eq}

  int n_checks;
  int n_errors;

  comparator_search_if #(.WIDTH(4), .CNTW(3)) bus ();

  comparator_search #(.WIDTH(4), .CNTW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.A_grt_B  = force_en ? force_flags[2] : (bus.guess > target);
  assign bus.A_less_B = force_en ? force_flags[1] : (bus.guess < target);
  assign bus.A_eq_B   = force_en ? force_flags[0] : (bus.guess == target);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      target;
    logic [3:0]      result;
    int              steps;
    logic [4:0][3:0] gs;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_guess"},  bus.guess,  0);
    chk({tag, "_busy"},   bus.busy,   0);
    chk({tag, "_done"},   bus.done,   0);
    chk({tag, "_found"},  bus.found,  0);
    chk({tag, "_err"},    bus.err,    0);
    chk({tag, "_result"}, bus.result, 0);
    chk({tag, "_steps"},  bus.steps,  0);
  endtask

  task automatic run_vec(input vec_t v);
    int idx;
    int cyc;
    @(negedge clk);
    target    = v.target;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    idx = 0;
    cyc = 0;
    while (!bus.done && cyc < 12) begin
      if (bus.busy) begin
        if (idx < 5) chk($sformatf("t%0d_guess%0d", v.target, idx), bus.guess, v.gs[idx]);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("t%0d_done", v.target), bus.done, 1);
    chk($sformatf("t%0d_found", v.target), bus.found, 1);
    chk($sformatf("t%0d_err", v.target), bus.err, 0);
    chk($sformatf("t%0d_result", v.target), bus.result, v.result);
    chk($sformatf("t%0d_steps", v.target), bus.steps, v.steps);
    chk($sformatf("t%0d_busy_cycles", v.target), idx, v.steps);
    @(negedge clk);
    chk($sformatf("t%0d_done_pulse", v.target), bus.done, 0);
  endtask

  task automatic run_forced(input logic [2:0] flags);
    @(negedge clk);
    target    = 4'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    force_en    = 1'b1;
    force_flags = flags;
    @(negedge clk);
    chk($sformatf("f%b_done", flags), bus.done, 1);
    chk($sformatf("f%b_err", flags), bus.err, 1);
    chk($sformatf("f%b_found", flags), bus.found, 0);
    chk($sformatf("f%b_steps", flags), bus.steps, 1);
    chk($sformatf("f%b_busy", flags), bus.busy, 0);
    force_en = 1'b0;
    @(negedge clk);
    chk($sformatf("f%b_done_pulse", flags), bus.done, 0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int done_at [3];

    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    target      = 4'd0;
    force_en    = 1'b0;
    force_flags = 3'b000;

    vecs[0] = '{target: 4'd7,  result: 4'd7,  steps: 1, gs: {4'd0,  4'd0,  4'd0,  4'd0,  4'd7}};
    vecs[1] = '{target: 4'd0,  result: 4'd0,  steps: 4, gs: {4'd0,  4'd0,  4'd1,  4'd3,  4'd7}};
    vecs[2] = '{target: 4'd15, result: 4'd15, steps: 5, gs: {4'd15, 4'd14, 4'd13, 4'd11, 4'd7}};
    vecs[3] = '{target: 4'd14, result: 4'd14, steps: 4, gs: {4'd0,  4'd14, 4'd13, 4'd11, 4'd7}};
    vecs[4] = '{target: 4'd3,  result: 4'd3,  steps: 2, gs: {4'd0,  4'd0,  4'd0,  4'd3,  4'd7}};

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Every target must be located within WIDTH+1 comparisons
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      target    = 4'(t);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 12) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("sweep%0d_done", t), bus.done, 1);
      chk($sformatf("sweep%0d_found", t), bus.found, 1);
      chk($sformatf("sweep%0d_result", t), bus.result, t);
      chk($sformatf("sweep%0d_steps_le5", t), (bus.steps <= 3'd5) ? 1 : 0, 1);
      chk($sformatf("sweep%0d_err", t), bus.err, 0);
    end

    run_forced(3'b000);
    run_forced(3'b011);

    // Reset during the third SEARCH cycle aborts without a done pulse
    @(negedge clk);
    target    = 4'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk("midrst_no_done", bus.done, 0);
    chk("midrst_busy_held", bus.busy, 0);
    rst = 1'b0;
    run_vec('{target: 4'd12, result: 4'd12, steps: 4, gs: {4'd0, 4'd12, 4'd13, 4'd11, 4'd7}});

    // start pulses while busy are ignored; no extra search follows
    @(negedge clk);
    target    = 4'd15;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk("ign_done", bus.done, 1);
    chk("ign_steps", bus.steps, 5);
    chk("ign_result", bus.result, 15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("ign_idle_busy%0d", i), bus.busy, 0);
      chk($sformatf("ign_idle_steps%0d", i), bus.steps, 5);
    end

    // start held high: target 9 takes 3 comparisons, so done recurs every 5 cycles
    @(negedge clk);
    target    = 4'd9;
    bus.start = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40 && ndone < 3; c++) begin
      @(negedge clk);
      if (bus.done) begin
        done_at[ndone] = c;
        ndone++;
        chk($sformatf("b2b_found%0d", ndone), bus.found, 1);
        chk($sformatf("b2b_result%0d", ndone), bus.result, 9);
        chk($sformatf("b2b_steps%0d", ndone), bus.steps, 3);
      end
    end
    bus.start = 1'b0;
    chk("b2b_done_count", ndone, 3);
    if (ndone == 3) begin
      chk("b2b_period1", done_at[1] - done_at[0], 5);
      chk("b2b_period2", done_at[2] - done_at[1], 5);
    end
    cyc = 0;
    while ((bus.busy || bus.done) && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_drain", (bus.busy || bus.done) ? 1 : 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
